// File: rtl/simon_pkg.sv
// Simon key-schedule constants: z sequences, per-configuration round count and
// z index, the C constant, and the legality check for (WORD_W, KEY_WORDS).
package simon_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Row j holds z_j with the first published bit in bit 61 (read as [61-i]).
  localparam logic [61:0] Z_TAB [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  function automatic bit simon_legal(input int n, input int m);
    return (n == 16 && m == 4) ||
           (n == 24 && (m == 3 || m == 4)) ||
           (n == 32 && (m == 3 || m == 4)) ||
           (n == 48 && (m == 2 || m == 3)) ||
           (n == 64 && (m >= 2 && m <= 4));
  endfunction

  function automatic int simon_rounds(input int n, input int m);
    if (n == 16) return 32;
    if (n == 24) return (m == 3) ? 36 : 36;
    if (n == 32) return (m == 3) ? 42 : 44;
    if (n == 48) return (m == 2) ? 52 : 54;
    if (n == 64) return (m == 2) ? 68 : (m == 3) ? 69 : 72;
    return 0;
  endfunction

  function automatic int simon_z_idx(input int n, input int m);
    if (n == 16) return 0;
    if (n == 24) return (m == 3) ? 0 : 1;
    if (n == 32) return (m == 3) ? 2 : 3;
    if (n == 48) return (m == 2) ? 2 : 3;
    if (n == 64) return (m == 2) ? 2 : (m == 3) ? 3 : 4;
    return 0;
  endfunction

  // C = 2^n - 4, returned zero-extended to 64 bits.
  function automatic logic [63:0] simon_c(input int n);
    logic [63:0] msk;
    msk = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return msk - 64'd3;
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon key-expansion step: the new key word appended after each round.
module simon_key_step
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic [KEY_WORDS-1:0][WORD_W-1:0] kr_i,
  input  logic                             z_i,
  output logic [WORD_W-1:0]                new_o
);

  localparam logic [WORD_W-1:0] C = WORD_W'(simon_c(WORD_W));

  logic [WORD_W-1:0] t;

  // T = ror(k[m-1],3) (^ k[1] for four-word keys); NEW = C ^ z ^ k[0] ^ T ^ ror(T,1)
  always_comb begin
    t = {kr_i[KEY_WORDS-1][2:0], kr_i[KEY_WORDS-1][WORD_W-1:3]};
    if (KEY_WORDS == 4) t = t ^ kr_i[1];
    new_o = C ^ WORD_W'(z_i) ^ kr_i[0] ^ t ^ {t[0], t[WORD_W-1:1]};
  end

endmodule

// File: rtl/simon_key_sched.sv
// Simon key-expansion engine: accepts a master key, streams ROUNDS subkeys in
// round order over valid/ready, one per cycle when the consumer is ready.
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
  input  logic                          key_in_vld,
  output logic                          key_in_rdy,
  output logic [WORD_W-1:0]             subkey_out,
  output logic [6:0]                    subkey_round,
  output logic                          subkey_last,
  output logic                          subkey_out_vld,
  input  logic                          subkey_out_rdy
);

  localparam int          ROUNDS = simon_rounds(WORD_W, KEY_WORDS);
  localparam int          Z_IDX  = simon_z_idx(WORD_W, KEY_WORDS);
  localparam logic [61:0] ZROW   = Z_TAB[Z_IDX];
  localparam logic [6:0]  LAST_R = 7'(ROUNDS - 1);

  if (!simon_legal(WORD_W, KEY_WORDS)) begin : g_bad_cfg
    $error("simon_key_sched: illegal (WORD_W, KEY_WORDS) pair");
  end

  state_e                           state_q, state_d;
  logic [KEY_WORDS-1:0][WORD_W-1:0] kr_q, kr_d;
  logic [6:0]                       r_q, r_d;
  logic [5:0]                       zc_q, zc_d;   // r mod 62, kept separately
  logic [WORD_W-1:0]                new_w;

  simon_key_step #(.WORD_W(WORD_W), .KEY_WORDS(KEY_WORDS)) u_step (
    .kr_i  (kr_q),
    .z_i   (ZROW[6'd61 - zc_q]),
    .new_o (new_w)
  );

  // Outputs come straight from registers; nothing combinational from inputs.
  assign key_in_rdy     = (state_q == ST_IDLE);
  assign subkey_out_vld = (state_q == ST_RUN);
  assign subkey_out     = kr_q[0];
  assign subkey_round   = r_q;
  assign subkey_last    = (state_q == ST_RUN) && (r_q == LAST_R);

  // Key capture in IDLE; shift-and-append on each subkey handshake in RUN.
  always_comb begin
    state_d = state_q;
    kr_d    = kr_q;
    r_d     = r_q;
    zc_d    = zc_q;
    case (state_q)
      ST_IDLE: if (key_in_vld) begin
        kr_d    = key_in;
        r_d     = '0;
        zc_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: if (subkey_out_rdy) begin
        for (int i = 0; i < KEY_WORDS - 1; i++) kr_d[i] = kr_q[i+1];
        kr_d[KEY_WORDS-1] = new_w;
        zc_d = (zc_q == 6'd61) ? 6'd0 : zc_q + 6'd1;
        if (r_q == LAST_R) begin
          r_d     = '0;   // park the index at 0 so it only ever shows 0..ROUNDS-1
          state_d = ST_IDLE;
        end else begin
          r_d = r_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kr_q    <= '0;
      r_q     <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      kr_q    <= kr_d;
      r_q     <= r_d;
      zc_q    <= zc_d;
    end
  end

endmodule

// File: tb/tb_simon_key_sched.sv
// Bench for simon_key_sched: one instance per legal (n,m) configuration,
// directed keys compared against an independent reference key schedule.
module tb_simon_key_sched;

  localparam int NCFG = 10;
  localparam int CN [NCFG] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CM [NCFG] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};

  typedef struct {
    int rounds;   // expected schedule length
    int zidx;     // expected z sequence
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [255:0] key_all = '0;
  logic [NCFG-1:0] kvld = '0;
  logic [NCFG-1:0] ordy = '0;
  wire  [NCFG-1:0] krdy, ovld, olast;
  wire  [NCFG-1:0][6:0]  rnd;
  wire  [NCFG-1:0][63:0] sk;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [CN[g]-1:0] so;
    assign sk[g] = 64'(so);
    simon_key_sched #(.WORD_W(CN[g]), .KEY_WORDS(CM[g])) u_dut (
      .clk            (clk),
      .rst            (rst),
      .key_in         (key_all[CN[g]*CM[g]-1:0]),
      .key_in_vld     (kvld[g]),
      .key_in_rdy     (krdy[g]),
      .subkey_out     (so),
      .subkey_round   (rnd[g]),
      .subkey_last    (olast[g]),
      .subkey_out_vld (ovld[g]),
      .subkey_out_rdy (ordy[g])
    );
  end

  int checks = 0;
  int errors = 0;
  cfg_t tbl [NCFG];
  logic [63:0] exp_k [72];
  logic [63:0] k5 [5];
  string zs [5];

  localparam logic [255:0] K3264 = 256'h1918_1110_0908_0100;
  localparam logic [255:0] K2    = 256'hA5A5_3C3C_0FF0_1234;
  localparam logic [255:0] K96   = 256'h13121110_0b0a0908_03020100;
  localparam logic [255:0] K128  = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] KS    = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_C0FFEE11_5A5A5A5A_0F1E2D3C;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int s, input int n,
                                     input logic [63:0] msk);
    return ((x >> s) | (x << (n - s))) & msk;
  endfunction

  // Reference schedule, written straight from the key-expansion recurrence.
  task automatic model(input int n, input int m, input int nr, input int zi,
                       input logic [255:0] key);
    logic [63:0] msk, t, nw;
    logic [63:0] kw [4];
    msk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < 4; i++) kw[i] = (i < m) ? (64'(key >> (i * n)) & msk) : 64'd0;
    for (int r = 0; r < nr; r++) begin
      exp_k[r] = kw[0];
      t  = ror(kw[m-1], 3, n, msk) ^ ((m == 4) ? kw[1] : 64'd0);
      nw = (msk - 64'd3) ^ ((zs[zi].getc(r % 62) == 8'h31) ? 64'd1 : 64'd0)
           ^ kw[0] ^ t ^ ror(t, 1, n, msk);
      for (int i = 0; i < m - 1; i++) kw[i] = kw[i+1];
      kw[m-1] = nw;
    end
  endtask

  // Load one key into instance idx and drain its whole schedule.
  // mode 0: consumer always ready; 1: random ready.  hold: keep key_in_vld
  // high through the run with key2 on the bus (must be ignored).
  task automatic run(input int idx, input logic [255:0] key, input int mode,
                     input bit hold, input logic [255:0] key2);
    int nr, cnt, cyc;
    bit pstall, rdy;
    logic [63:0] psk;
    logic [6:0]  prnd;
    logic        plast;
    nr = tbl[idx].rounds;
    model(CN[idx], CM[idx], nr, tbl[idx].zidx, key);
    cyc = 0;
    while (!krdy[idx] && cyc < 100) begin @(negedge clk); cyc++; end
    chk("key_in_rdy_before_load", 64'(krdy[idx]), 64'd1);
    key_all = key; kvld[idx] = 1'b1; ordy[idx] = 1'b0;
    @(negedge clk);
    if (hold) key_all = key2; else kvld[idx] = 1'b0;
    cnt = 0; cyc = 0; pstall = 0; psk = '0; prnd = '0; plast = 1'b0;
    while (cnt < nr && cyc < 2000) begin
      chk("vld_in_run", 64'(ovld[idx]), 64'd1);
      chk("key_in_rdy_in_run", 64'(krdy[idx]), 64'd0);
      if (pstall) begin
        chk("stall_hold_subkey", sk[idx], psk);
        chk("stall_hold_round", 64'(rnd[idx]), 64'(prnd));
        chk("stall_hold_last", 64'(olast[idx]), 64'(plast));
      end
      chk("subkey_round", 64'(rnd[idx]), 64'(cnt));
      chk("subkey", sk[idx], exp_k[cnt]);
      chk("subkey_last", 64'(olast[idx]), 64'(cnt == nr - 1));
      if (idx == 0 && key == K3264 && cnt < 5) chk("simon32_64_known", sk[idx], k5[cnt]);
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ordy[idx] = rdy;
      psk = sk[idx]; prnd = rnd[idx]; plast = olast[idx]; pstall = !rdy;
      if (rdy) cnt++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("run_timeout", 64'(cnt), 64'(nr));
    ordy[idx] = 1'b0;
    // Bubble cycle right after the last handshake.
    chk("vld_dropped_after_last", 64'(ovld[idx]), 64'd0);
    chk("key_in_rdy_after_last", 64'(krdy[idx]), 64'd1);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{32, 0}; tbl[1] = '{36, 0}; tbl[2] = '{36, 1}; tbl[3] = '{42, 2};
    tbl[4] = '{44, 3}; tbl[5] = '{52, 2}; tbl[6] = '{54, 3}; tbl[7] = '{68, 2};
    tbl[8] = '{69, 3}; tbl[9] = '{72, 4};
    k5 = '{64'h0100, 64'h0908, 64'h1110, 64'h1918, 64'h71C3};
    zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
    zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
    zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
    zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
    zs[4] = "11010001111001101011011000100000010111000011001010010011101111";

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_key_in_rdy", 64'(krdy[0]), 64'd1);
    chk("rst_vld", 64'(ovld[0]), 64'd0);
    chk("rst_last", 64'(olast[0]), 64'd0);
    chk("rst_round", 64'(rnd[0]), 64'd0);
    chk("rst_subkey", sk[0], 64'd0);
    chk("rst_all_rdy", 64'(krdy), {54'd0, {NCFG{1'b1}}});
    rst = 1'b0;
    @(negedge clk);

    // Simon32/64 with ready held high, then with random backpressure
    run(0, K3264, 0, 1'b0, '0);
    run(0, K3264, 1, 1'b0, '0);

    // Simon128/256: z wrap past round 62, round index reaches 71
    run(9, K128, 0, 1'b0, '0);

    // Back-to-back keys with key_in_vld held high; K2 on the bus during the
    // first run must not disturb it, then K2 is taken after one bubble.
    run(0, K3264, 0, 1'b1, K2);
    run(0, K2, 0, 1'b0, '0);

    // Reset at round 10 of Simon64/96, then a full fresh schedule
    key_all = K96; kvld[3] = 1'b1; ordy[3] = 1'b1;
    @(negedge clk);
    kvld[3] = 1'b0;
    cyc = 0;
    while (rnd[3] != 7'd10 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("reach_round_10", 64'(rnd[3]), 64'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_vld", 64'(ovld[3]), 64'd0);
    chk("midrst_key_in_rdy", 64'(krdy[3]), 64'd1);
    chk("midrst_round", 64'(rnd[3]), 64'd0);
    chk("midrst_last", 64'(olast[3]), 64'd0);
    rst = 1'b0; ordy[3] = 1'b0;
    @(negedge clk);
    run(3, K96, 0, 1'b0, '0);

    // Sweep every legal configuration
    for (int i = 0; i < NCFG; i++) run(i, KS, i % 2, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_key_sched.md
Name: simon_key_sched

Overview:
- Parametrised Simon key-expansion engine covering all ten Simon block/key configurations via WORD_W and KEY_WORDS.
- Accepts one master key per handshake and streams the round keys k[0]..k[ROUNDS-1] one word per cycle over a valid/ready interface.
- Sits between the key-load path and the Simon round datapath, which consumes subkeys in round order.

Parameters:
WORD_W, 16, Simon word size n; legal values 16, 24, 32, 48, 64.
KEY_WORDS, 4, key words m; legal (n,m): (16,4) (24,3) (24,4) (32,3) (32,4) (48,2) (48,3) (64,2) (64,3) (64,4); any other pair is an elaboration error.

Ports:
clk  in  1  clock; all logic is clocked on its rising edge.
rst  in  1  reset, synchronous, active-high.
key_in  in  KEY_WORDS*WORD_W  master key; word k[i] occupies bits [(i+1)*WORD_W-1 : i*WORD_W], so k[0] sits in the LSBs.
key_in_vld  in  1  key valid.
key_in_rdy  out  1  engine idle and able to accept a key.
subkey_out  out  WORD_W  current round key.
subkey_round  out  7  round index of subkey_out, 0..ROUNDS-1.
subkey_last  out  1  high while subkey_out is round ROUNDS-1.
subkey_out_vld  out  1  subkey valid.
subkey_out_rdy  in  1  consumer accepts subkey.

Behaviour:
- Derived constants (package functions of n,m):
  - ROUNDS = 32, 36, 36, 42, 44, 52, 54, 68, 69, 72.
  - Z_IDX = 0, 0, 1, 2, 3, 2, 3, 2, 3, 4 (same configuration order as Parameters).
  - C = 2^WORD_W - 4.
- State: key register kr[0..m-1], 7-bit round counter r, FSM {IDLE, RUN}.
- Reset: state=IDLE; kr=0; r=0; subkey_out_vld=0; subkey_last=0; subkey_round=0; subkey_out=0; key_in_rdy=1.
- key_in_rdy = (state==IDLE). Registered, with no combinational path from any input.
- Key accept (IDLE and key_in_vld):
  - kr[i] <= k[i]; r <= 0; state <= RUN.
  - subkey_out_vld goes high the next cycle (1-cycle latency); subkey_out = kr[0].
- RUN outputs: subkey_out = kr[0]; subkey_round = r; subkey_last = (r==ROUNDS-1); subkey_out_vld = 1.
- Output handshake (vld and rdy):
  - Shift kr[i] <= kr[i+1] for i < m-1; kr[m-1] <= NEW.
  - r <= r+1.
  - If r==ROUNDS-1: state <= IDLE and vld drops the next cycle.
- NEW = C ^ z[Z_IDX][r mod 62] ^ kr[0] ^ T ^ ror(T,1), where T = ror(kr[m-1],3) ^ (m==4 ? kr[1] : 0). ror is rotate right within WORD_W.
- z-index wrap: r mod 62 is implemented as a separate 6-bit counter that wraps 61->0. The wrap is exercised only when ROUNDS > 62 (the 64-bit-word configurations).
- Backpressure: while vld and !rdy, subkey_out, subkey_round, subkey_last and kr are held stable. No round is skipped or repeated.
- Throughput: one subkey per cycle while rdy is held high.
- Back-to-back keys: key_in_rdy returns high the cycle after the last handshake, giving exactly one bubble cycle between keys.
- key_in_vld while in RUN is ignored; no key is captured.
- rst mid-RUN returns all outputs to reset values the next cycle; the partially emitted schedule is discarded.
- If the last subkey handshake and rst coincide, rst wins.

Decomposition:
- Package simon_pkg:
  - Z table: 5 x 62 bits, z[j][0] = first bit of the published sequence.
  - Functions simon_rounds(n,m) and simon_z_idx(n,m), plus a legality check function.
  - Constant builder for C.
- Sub-module simon_key_step: combinational NEW-word computation, with inputs kr words, z bit and WORD_W/KEY_WORDS parameters. Instantiated once.

Test Plan:
- Simon32/64, key words k3..k0 = 1918 1110 0908 0100, rdy held high:
  - Subkeys 0100, 0908, 1110, 1918, 71C3 on 5 consecutive cycles starting 1 cycle after accept.
  - Exactly 32 subkeys; subkey_last only at round 31.
- Same key with rdy toggled pseudo-randomly:
  - Identical 32-word sequence.
  - subkey_out stable on every vld & !rdy cycle.
  - No duplicate or dropped rounds.
- Simon128/256 (WORD_W=64, KEY_WORDS=4), key 1f1e..0100:
  - All 72 subkeys match the golden model, covering the z wrap at round 62.
  - subkey_round reaches 71.
- Two keys back-to-back with key_in_vld held high:
  - Second key accepted exactly 1 cycle after the last handshake of the first.
  - key_in_vld asserted during RUN leaves kr unchanged.
- Assert rst at round 10 of Simon64/96:
  - Next cycle: vld=0, key_in_rdy=1, subkey_round=0.
  - A fresh key then produces a correct full 42-round schedule.
- Sweep all ten legal (n,m) pairs against the reference model: correct ROUNDS and every subkey.
